fp_cmd_scheduler: RTL and testbench
===================================

FP_CMD_SCHEDULER -- requirements
Module: fp_cmd_scheduler

Interface
REQ-001 Parameter EXEC_TIMEOUT, default 255: max cycles to wait for exec_done before aborting an operation.
REQ-002 Parameter FIFO_DEPTH, default 2: number of complete command frames buffered.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_done  input  1  I2C slave word-received flag, synchronous to clk, high for >=1 cycle per word.
REQ-006 rx_data  input  32  received word, stable while rx_done high.
REQ-007 exec_start  output  1  one-cycle launch pulse to the execution unit (add/sub/fp_multiplier wrapper).
REQ-008 exec_opcode  output  2  operation: 00 ADD, 01 SUB, 10 MULT.
REQ-009 exec_a, exec_b  output  32 each  operands, held stable from exec_start until exec_done or timeout.
REQ-010 exec_done  input  1  one-cycle completion pulse from execution unit.
REQ-011 exec_result  input  32  result, valid in the exec_done cycle.
REQ-012 res_valid  output  1  result available to the OLED formatter.
REQ-013 res_ready  input  1  OLED formatter accepts result.
REQ-014 res_opcode  output  2  opcode of the presented result.
REQ-015 res_data  output  32  presented result value.
REQ-016 res_err  output  1  presented result came from a timeout.
REQ-017 overflow  output  1  one-cycle pulse when a complete frame is dropped.
REQ-018 word_idx  output  2  words received in the current frame (0..2).
REQ-019 busy  output  1  high whenever scheduler FSM is not IDLE or FIFO is non-empty.

Function
REQ-020 Word capture SHALL occur on the rising edge of rx_done (registered previous value); level held high counts once.
REQ-021 Captured words SHALL be assigned in order opcode, operand A, operand B; word_idx increments 0->1->2, and the third word wraps word_idx to 0 and completes the frame.
REQ-022 A completed frame SHALL be pushed into the FIFO in the cycle after the third capture edge.
REQ-023 Push when FIFO full SHALL drop the new frame, leave FIFO contents unchanged, and pulse overflow for exactly one cycle.
REQ-024 Simultaneous push and pop SHALL both succeed, including when the FIFO is full.
REQ-025 Scheduler FSM states: IDLE, ISSUE, WAIT, PRESENT.
REQ-026 IDLE: if the FIFO is non-empty, pop the head frame into working registers and go to ISSUE; otherwise stay.
REQ-027 ISSUE: opcode[1:0]=11 (NOP) skips execution, loads res_data=32'hFFFF_FFFF, res_err=0, and goes to PRESENT; otherwise assert exec_start for one cycle, clear the timeout counter, and go to WAIT.
REQ-028 WAIT: exec_done latches exec_result into res_data, sets res_err=0, and goes to PRESENT.
REQ-029 WAIT: the timeout counter SHALL increment each cycle; reaching EXEC_TIMEOUT without exec_done sets res_data=0 and res_err=1, then goes to PRESENT.
REQ-030 exec_done arriving outside WAIT SHALL be ignored.
REQ-031 PRESENT: res_valid=1, and res_data, res_opcode, and res_err SHALL stay stable until the res_valid&&res_ready cycle, then go to IDLE.
REQ-032 Latency: with an empty FIFO and res_ready held high, exec_start SHALL assert 3 cycles after the third rx_done rising edge (push, pop, issue).
REQ-033 Only opcode[1:0] is decoded; opcode[31:2] SHALL be ignored.
REQ-034 Word capture and FIFO push SHALL continue independently of the scheduler state.

Reset
REQ-035 Asserting rst_n low SHALL immediately clear: FSM to IDLE, FIFO empty, word_idx=0, timeout counter=0, and rx_done edge register=0.
REQ-036 During reset all outputs SHALL be 0, including exec_start, res_valid, res_data, res_opcode, res_err, overflow, and busy.
REQ-037 Reset asserted mid-frame or mid-WAIT SHALL discard the partial frame or in-flight operation; an exec_done after release SHALL be ignored.
REQ-038 The first rising edge of rx_done after reset release SHALL be captured as an opcode.

Verification
REQ-039 Send words 2, 3F800000, 40000000, model exec_done after 4 cycles with result 40000000 -> exec_opcode=10, res_valid with res_data=40000000, res_opcode=10, res_err=0.
REQ-040 Send opcode 3 with any operands -> no exec_start; res_data=FFFFFFFF, res_opcode=11.
REQ-041 Hold res_ready=0 and send 4 frames -> FIFO holds 2 frames, overflow pulses once for the 4th frame; after ready, results for frames 1-3 are delivered in order.
REQ-042 Issue opcode 0 and never return exec_done -> after EXEC_TIMEOUT cycles, res_err=1 and res_data=0; a late exec_done is ignored.
REQ-043 Hold rx_done high for 10 cycles -> only one word captured; word_idx=1.
REQ-044 Pull rst_n low after 2 words, then send a full frame -> frame decoded from the new words only, with all outputs 0 during reset.

Source files
------------

// File: rtl/fp_cmd_scheduler.sv
// Command scheduler between an I2C slave word receiver and an FP execution unit.
// Collects 3-word frames (opcode, operand A, operand B) and buffers them in a
// small FIFO. A scheduler FSM launches each frame and presents the result with
// a valid/ready handshake.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   rx_done, rx_data             received word strobe / data
//   exec_start/opcode/a/b        launch interface to the execution unit
//   exec_done, exec_result       completion from the execution unit
//   res_valid/ready/opcode/data/err  result presentation
//   overflow                     pulse when a complete frame is dropped
//   word_idx                     words received in the current frame
//   busy                         FSM active or FIFO non-empty
module fp_cmd_scheduler #(
  parameter int unsigned EXEC_TIMEOUT = 255,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [31:0] rx_data,
  output logic        exec_start,
  output logic [1:0]  exec_opcode,
  output logic [31:0] exec_a,
  output logic [31:0] exec_b,
  input  logic        exec_done,
  input  logic [31:0] exec_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_opcode,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        overflow,
  output logic [1:0]  word_idx,
  output logic        busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT + 1) : 1;
  localparam logic [1:0]  OP_NOP = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } frame_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;

  state_t          state, state_n;
  logic            rx_prev;
  logic            rx_rise;
  logic [1:0]      op_hold;
  logic [31:0]     a_hold;
  logic            push_pend;
  frame_t          push_frame;
  frame_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_n;
  logic            full, empty, push_ok, pop;
  frame_t          head;
  logic [TW-1:0]   tmo, tmo_n;
  logic            start_n, ld_nop, ld_done, ld_tmo;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rx_rise = rx_done & ~rx_prev;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_pend && (!full || pop);

  // Word capture on rx_done rising edge; the completed frame is pushed next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev    <= 1'b0;
      word_idx   <= 2'd0;
      op_hold    <= 2'd0;
      a_hold     <= 32'd0;
      push_pend  <= 1'b0;
      push_frame <= '0;
    end else begin
      rx_prev   <= rx_done;
      push_pend <= 1'b0;
      if (rx_rise) begin
        case (word_idx)
          2'd0: begin
            op_hold  <= rx_data[1:0];
            word_idx <= 2'd1;
          end
          2'd1: begin
            a_hold   <= rx_data;
            word_idx <= 2'd2;
          end
          default: begin
            push_frame <= {op_hold, a_hold, rx_data};
            push_pend  <= 1'b1;
            word_idx   <= 2'd0;
          end
        endcase
      end
    end
  end

  // FIFO occupancy next value.
  always_comb begin
    count_n = count;
    if (push_ok && !pop)      count_n = count + CW'(1);
    else if (!push_ok && pop) count_n = count - CW'(1);
  end

  // FIFO pointers and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_n;
      overflow <= push_pend && full && !pop;
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_frame;
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Scheduler next-state and control. exec_start is launched while entering
  // ISSUE so it is high during the ISSUE cycle.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    start_n = 1'b0;
    tmo_n   = tmo;
    ld_nop  = 1'b0;
    ld_done = 1'b0;
    ld_tmo  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          start_n = (head.op != OP_NOP);
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tmo_n = '0;
        if (exec_opcode == OP_NOP) begin
          ld_nop  = 1'b1;
          state_n = PRESENT;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (exec_done) begin
          ld_done = 1'b1;
          state_n = PRESENT;
        end else if ((tmo + TW'(1)) >= TW'(EXEC_TIMEOUT)) begin
          ld_tmo  = 1'b1;
          state_n = PRESENT;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      PRESENT: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Working registers, launch pulse and result presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_start  <= 1'b0;
      exec_opcode <= 2'd0;
      exec_a      <= 32'd0;
      exec_b      <= 32'd0;
      tmo         <= '0;
      res_valid   <= 1'b0;
      res_opcode  <= 2'd0;
      res_data    <= 32'd0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      exec_start <= start_n;
      tmo        <= tmo_n;
      res_valid  <= (state_n == PRESENT);
      busy       <= (state_n != IDLE) || (count_n != '0);
      if (pop) begin
        exec_opcode <= head.op;
        exec_a      <= head.a;
        exec_b      <= head.b;
      end
      if (ld_nop || ld_done || ld_tmo) res_opcode <= exec_opcode;
      if (ld_nop) begin
        res_data <= 32'hFFFF_FFFF;
        res_err  <= 1'b0;
      end else if (ld_done) begin
        res_data <= exec_result;
        res_err  <= 1'b0;
      end else if (ld_tmo) begin
        res_data <= 32'd0;
        res_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmd_scheduler.sv
// Directed testbench for fp_cmd_scheduler: table of frames plus hand-written
// sequences for overflow, held rx_done and reset corner cases.
module tb_fp_cmd_scheduler;

  localparam int unsigned TMO   = 12;
  localparam int          NEVER = -1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [31:0] rx_data;
  logic        exec_start;
  logic [1:0]  exec_opcode;
  logic [31:0] exec_a, exec_b;
  logic        exec_done;
  logic [31:0] exec_result;
  logic        res_valid, res_ready;
  logic [1:0]  res_opcode;
  logic [31:0] res_data;
  logic        res_err, overflow, busy;
  logic [1:0]  word_idx;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  typedef struct {
    logic [31:0] w0, w1, w2;
    int          dly;
    logic [31:0] res;
    bit          exp_start;
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  fp_cmd_scheduler #(.EXEC_TIMEOUT(TMO), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .exec_start(exec_start), .exec_opcode(exec_opcode), .exec_a(exec_a),
    .exec_b(exec_b), .exec_done(exec_done), .exec_result(exec_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_opcode(res_opcode),
    .res_data(res_data), .res_err(res_err), .overflow(overflow),
    .word_idx(word_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, {exec_start, exec_opcode, exec_a, exec_b, res_valid, res_opcode,
               res_data, res_err, overflow, word_idx, busy}, 128'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    if (overflow) ovf_cnt++;
    rx_data = w;
    rx_done = 1'b1;
    @(negedge clk);
    if (overflow) ovf_cnt++;
    rx_done = 1'b0;
    @(negedge clk);
    if (overflow) ovf_cnt++;
  endtask

  task automatic send_frame(input vec_t v);
    send_word(v.w0);
    send_word(v.w1);
    send_word(v.w2);
  endtask

  // Acts as the execution unit for one frame, then checks and accepts the result.
  task automatic serve(input string name, input vec_t v, input int exp_lat);
    int n, start_at, done_at, starts;
    n = 0; start_at = 0; done_at = -1; starts = 0;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
      exec_done = 1'b0;
      if (exec_start) begin
        starts++;
        if (starts == 1) begin
          start_at = n;
          chk({name, "_exec_op"}, exec_opcode, v.exp_op);
          chk({name, "_exec_a"}, exec_a, v.w1);
          chk({name, "_exec_b"}, exec_b, v.w2);
          if (exp_lat != 0) chk({name, "_latency"}, n, exp_lat);
          if (v.dly != NEVER) done_at = n + v.dly;
        end
      end
      if (n == done_at) begin
        exec_done   = 1'b1;
        exec_result = v.res;
      end
    end
    exec_done = 1'b0;
    chk({name, "_res_valid"}, res_valid, 1'b1);
    chk({name, "_starts"}, starts, v.exp_start ? 1 : 0);
    chk({name, "_res_data"}, res_data, v.exp_data);
    chk({name, "_res_op"}, res_opcode, v.exp_op);
    chk({name, "_res_err"}, res_err, v.exp_err);
    if (v.dly == NEVER && v.exp_start)
      chk({name, "_tmo_window"}, ((n - start_at) >= int'(TMO)) && ((n - start_at) <= int'(TMO) + 2), 1'b1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, "_released"}, res_valid, 1'b0);
  endtask

  initial begin
    vec_t v;
    int starts;
    rst_n = 1'b0; rx_done = 1'b0; rx_data = '0;
    exec_done = 1'b0; exec_result = '0; res_ready = 1'b0;

    vecs[0] = '{32'h2, 32'h3F80_0000, 32'h4000_0000, 4, 32'h4000_0000, 1'b1, 32'h4000_0000, 2'b10, 1'b0};
    vecs[1] = '{32'h3, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h0, 1'b0, 32'hFFFF_FFFF, 2'b11, 1'b0};
    vecs[2] = '{32'h0, 32'h1, 32'h2, 1, 32'h3, 1'b1, 32'h3, 2'b00, 1'b0};
    vecs[3] = '{32'hFFFF_FFFD, 32'hA, 32'hB, 7, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA, 2'b01, 1'b0};
    vecs[4] = '{32'h0, 32'hC0DE, 32'hBEEF, NEVER, 32'h0, 1'b1, 32'h0, 2'b00, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'hFFFF_FFFF, 2'b11, 1'b0};

    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs_zero("post_reset_idle");

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i]);
      serve($sformatf("vec%0d", i), vecs[i], (i == 0) ? 1 : 0);
      if (vecs[i].dly == NEVER) begin
        @(negedge clk); exec_done = 1'b1; exec_result = 32'hDEAD_BEEF;
        @(negedge clk); exec_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_valid", res_valid, 1'b0);
        chk("late_done_busy", busy, 1'b0);
      end
    end

    // Overflow: first frame presented but not accepted, two buffered, fourth dropped.
    ovf_cnt = 0;
    v = '{32'h3, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'hFFFF_FFFF, 2'b11, 1'b0};
    send_frame(v);
    v = '{32'h0, 32'hA2, 32'hB2, 2, 32'h2222, 1'b1, 32'h2222, 2'b00, 1'b0};
    send_frame(v);
    v = '{32'h1, 32'hA3, 32'hB3, 3, 32'h3333, 1'b1, 32'h3333, 2'b01, 1'b0};
    send_frame(v);
    chk("ovf_before_4th", ovf_cnt, 0);
    v = '{32'h2, 32'hA4, 32'hB4, 2, 32'h4444, 1'b1, 32'h4444, 2'b10, 1'b0};
    send_frame(v);
    repeat (2) begin @(negedge clk); if (overflow) ovf_cnt++; end
    chk("ovf_count", ovf_cnt, 1);
    chk("ovf_busy", busy, 1'b1);
    serve("ovf_f1", '{32'h3, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'hFFFF_FFFF, 2'b11, 1'b0}, 0);
    serve("ovf_f2", '{32'h0, 32'hA2, 32'hB2, 2, 32'h2222, 1'b1, 32'h2222, 2'b00, 1'b0}, 0);
    serve("ovf_f3", '{32'h1, 32'hA3, 32'hB3, 3, 32'h3333, 1'b1, 32'h3333, 2'b01, 1'b0}, 0);
    starts = 0;
    repeat (20) begin @(negedge clk); if (exec_start || res_valid) starts++; end
    chk("ovf_f4_dropped", starts, 0);
    chk("ovf_drained_busy", busy, 1'b0);

    // rx_done held high counts once.
    @(negedge clk);
    rx_data = 32'h1; rx_done = 1'b1;
    repeat (10) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    chk("held_rx_word_idx", word_idx, 2'd1);
    send_word(32'h7);
    send_word(32'h8);
    serve("held_rx", '{32'h1, 32'h7, 32'h8, 2, 32'h15, 1'b1, 32'h15, 2'b01, 1'b0}, 0);

    // Reset mid-frame discards the partial frame.
    send_word(32'h2);
    send_word(32'h1111);
    chk("midframe_word_idx", word_idx, 2'd2);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midframe_reset_async");
    repeat (2) @(negedge clk);
    chk_outs_zero("midframe_reset_held");
    rst_n = 1'b1;
    v = '{32'h1, 32'h5, 32'h6, 2, 32'h11, 1'b1, 32'h11, 2'b01, 1'b0};
    send_frame(v);
    serve("after_rst", v, 1);

    // Reset mid-WAIT, then a stale exec_done must be ignored.
    v = '{32'h0, 32'h9, 32'hA, NEVER, 32'h0, 1'b1, 32'h0, 2'b00, 1'b1};
    send_frame(v);
    starts = 0;
    for (int k = 0; k < 10 && starts == 0; k++) begin
      @(negedge clk);
      if (exec_start) starts = 1;
    end
    chk("midwait_started", starts, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midwait_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); exec_done = 1'b1; exec_result = 32'hBAD0_BAD0;
    @(negedge clk); exec_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("midwait_stale_valid", res_valid, 1'b0);
    chk("midwait_stale_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
